// File: rtl/esp32_boot_pkg.sv
// Shared types for the ESP32 EN/GPIO0 strap sequencer: FSM states, decoded
// host requests and the strap levels driven in each state.
package esp32_boot_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    RST_LOW    = 2'b01,
    BOOT_STRAP = 2'b10
  } seq_state_t;

  typedef enum logic [1:0] {
    REQ_RELEASE = 2'b00,
    REQ_RESET   = 2'b01,
    REQ_BOOT    = 2'b10
  } req_t;

  typedef struct packed {
    logic en;
    logic gpio0;
  } strap_t;

  // Raw {ndtr,nrts} level that decodes to RELEASE; used as the synchroniser reset value.
  localparam logic [1:0] REQ_RAW_RELEASE = 2'b11;

  localparam strap_t STRAP_IDLE = '{en: 1'b1, gpio0: 1'b1};
  localparam strap_t STRAP_RST  = '{en: 1'b0, gpio0: 1'b1};
  localparam strap_t STRAP_BOOT = '{en: 1'b1, gpio0: 1'b0};

  function automatic req_t decode_req(input logic [1:0] ndtr_nrts);
    case (ndtr_nrts)
      2'b10:   return REQ_RESET;
      2'b01:   return REQ_BOOT;
      default: return REQ_RELEASE;
    endcase
  endfunction

  function automatic strap_t strap_for(input seq_state_t s);
    case (s)
      IDLE:       return STRAP_IDLE;
      BOOT_STRAP: return STRAP_BOOT;
      default:    return STRAP_RST;
    endcase
  endfunction

endpackage

// File: rtl/esp32_strap_debounce.sv
// N-bit synchroniser followed by a stability-count debouncer: dout only takes
// a new value after the synchronised input has held it for DEBOUNCE_CYCLES samples.
module esp32_strap_debounce #(
  parameter int               WIDTH           = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 250,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] RUN_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  din_sync;
  logic [WIDTH-1:0]                  cand_reg;
  logic [WIDTH-1:0]                  dout_reg;
  logic [CNT_W-1:0]                  cnt_reg;
  logic [CNT_W-1:0]                  run_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_reg[i] <= sync_reg[i-1];
      end
      sync_reg[0] <= din;
    end
  end

  assign din_sync = sync_reg[SYNC_STAGES-1];

  // Length of the current run of identical samples, including this one; any
  // change of value (glitch or new request) restarts the run at 1.
  assign run_len = (din_sync == cand_reg) ? cnt_reg + CNT_W'(1) : CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg <= RESET_VALUE;
      dout_reg <= RESET_VALUE;
      cnt_reg  <= '0;
    end else begin
      cand_reg <= din_sync;
      if (din_sync == dout_reg) begin
        cnt_reg <= '0;
      end else if (run_len >= RUN_DONE) begin
        dout_reg <= din_sync;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= run_len;
      end
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/esp32_boot_sequencer.sv
// Timed EN/GPIO0 strap sequencer for the ESP32 behind the FTDI DTR/RTS lines.
// Optional boot-strap idle timeout with lockout is enabled by ESP32_BOOT_TIMEOUT_EN.
module esp32_boot_sequencer
  import esp32_boot_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int DEBOUNCE_CYCLES     = 250,
  parameter int EN_LOW_MIN_CYCLES   = 250000,
  parameter int GPIO0_HOLD_CYCLES   = 25000,
  parameter int BOOT_TIMEOUT_CYCLES = 25000000
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic       ftdi_ndtr,
  input  logic       ftdi_nrts,
  input  logic       ftdi_txd,
  output logic       wifi_en,
  output logic       wifi_gpio0,
  output logic [1:0] seq_state,
  output logic       boot_timeout
);

  localparam int MAX_HOLD = (EN_LOW_MIN_CYCLES > GPIO0_HOLD_CYCLES) ?
                            EN_LOW_MIN_CYCLES : GPIO0_HOLD_CYCLES;
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] EN_LOAD = CNT_W'(EN_LOW_MIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GP_LOAD = CNT_W'(GPIO0_HOLD_CYCLES - 1);

  logic [1:0] req_raw;
  req_t       req;

  esp32_strap_debounce #(
    .WIDTH           (2),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VALUE     (REQ_RAW_RELEASE)
  ) u_req_debounce (
    .clk   (clk_25mhz),
    .rst_n (rst_n),
    .din   ({ftdi_ndtr, ftdi_nrts}),
    .dout  (req_raw)
  );

  assign req = decode_req(req_raw);

  seq_state_t       state_reg, state_next;
  logic [CNT_W-1:0] seq_cnt_reg, seq_cnt_next;
  strap_t           strap_reg, strap_next;
  logic             hold_expired;
  logic             timeout_fire;
  logic             boot_expire;
  logic             lockout;

  assign hold_expired = (seq_cnt_reg == '0);

  always_comb begin
    state_next   = state_reg;
    seq_cnt_next = hold_expired ? seq_cnt_reg : seq_cnt_reg - CNT_W'(1);
    timeout_fire = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req == REQ_RESET) begin
          state_next   = RST_LOW;
          seq_cnt_next = EN_LOAD;
        end else if (req == REQ_BOOT && !lockout) begin
          state_next   = BOOT_STRAP;
          seq_cnt_next = GP_LOAD;
        end
      end
      RST_LOW: begin
        // Requests seen during the pulse are ignored; only the level at expiry counts.
        if (hold_expired) begin
          if (req == REQ_BOOT) begin
            state_next   = BOOT_STRAP;
            seq_cnt_next = GP_LOAD;
          end else if (req == REQ_RELEASE) begin
            state_next = IDLE;
          end
        end
      end
      BOOT_STRAP: begin
        if (hold_expired) begin
          if (req == REQ_RESET) begin
            state_next   = RST_LOW;
            seq_cnt_next = EN_LOAD;
          end else if (req == REQ_RELEASE) begin
            state_next = IDLE;
          end else if (boot_expire) begin
            state_next   = IDLE;
            timeout_fire = 1'b1;
          end
        end
      end
      default: begin
        state_next   = RST_LOW;
        seq_cnt_next = EN_LOAD;
      end
    endcase
    strap_next = strap_for(state_next);
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RST_LOW;
      seq_cnt_reg <= EN_LOAD;
      strap_reg   <= STRAP_RST;
    end else begin
      state_reg   <= state_next;
      seq_cnt_reg <= seq_cnt_next;
      strap_reg   <= strap_next;
    end
  end

  assign wifi_en    = strap_reg.en;
  assign wifi_gpio0 = strap_reg.gpio0;
  assign seq_state  = state_reg;

`ifdef ESP32_BOOT_TIMEOUT_EN
  localparam int ACT_W = $clog2(BOOT_TIMEOUT_CYCLES) + 1;
  localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(BOOT_TIMEOUT_CYCLES - 1);

  logic [1:0]       txd_sync_reg;
  logic             txd_prev_reg;
  logic             txd_edge;
  logic             hold_done_reg;
  logic [ACT_W-1:0] act_cnt_reg;
  logic             lockout_reg;
  logic             boot_timeout_reg;

  assign txd_edge    = txd_sync_reg[1] ^ txd_prev_reg;
  assign boot_expire = hold_done_reg && !txd_edge && (act_cnt_reg == ACT_LAST);
  assign lockout     = lockout_reg;

  // Activity counting starts the cycle after the GPIO0 hold has expired.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      txd_sync_reg     <= 2'b11;
      txd_prev_reg     <= 1'b1;
      hold_done_reg    <= 1'b0;
      act_cnt_reg      <= '0;
      lockout_reg      <= 1'b0;
      boot_timeout_reg <= 1'b0;
    end else begin
      txd_sync_reg  <= {txd_sync_reg[0], ftdi_txd};
      txd_prev_reg  <= txd_sync_reg[1];
      hold_done_reg <= (state_reg == BOOT_STRAP) && (state_next == BOOT_STRAP) && hold_expired;
      if (!hold_done_reg || txd_edge) begin
        act_cnt_reg <= '0;
      end else if (act_cnt_reg != ACT_LAST) begin
        act_cnt_reg <= act_cnt_reg + ACT_W'(1);
      end
      if (timeout_fire) begin
        lockout_reg <= 1'b1;
      end else if (req == REQ_RELEASE) begin
        lockout_reg <= 1'b0;
      end
      if (timeout_fire) begin
        boot_timeout_reg <= 1'b1;
      end else if (req == REQ_RESET) begin
        boot_timeout_reg <= 1'b0;
      end
    end
  end

  assign boot_timeout = boot_timeout_reg;
`else
  logic unused_timeout;

  assign boot_expire    = 1'b0;
  assign lockout        = 1'b0;
  assign boot_timeout   = 1'b0;
  assign unused_timeout = ftdi_txd ^ timeout_fire ^ (BOOT_TIMEOUT_CYCLES > 0);
`endif

endmodule
